mem_wb: RTL and testbench

- Memory/writeback stage directly downstream of the execute stage.
- Accepts one executed instruction per handshake: address, data, register write-enable and memory control.
- Non-memory results are written back to the register file in the acceptance cycle.
- Loads and stores go through a single-outstanding request/acknowledge data bus; `o_ready` backpressures execute until the access completes.

---
 rtl/mem_wb.sv | 137 +++++++++++++
 tb/tb_mem_wb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// mem_wb: memory/writeback stage after execute.
// Non-memory results are written back in the cycle they are accepted.
// Loads and stores go out on a bus that allows one outstanding request.
// While that request is open, o_ready holds off execute.
//
//   state | meaning
//   IDLE  | no bus access open; ALU results write back directly
//   BUSY  | request driven from captured fields, waiting for i_mem_ack

module mem_wb #(
   parameter int RW    = 16,
   parameter int REGNO = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_submit,
   output logic             o_ready,
   input  logic [RW-1:0]    i_data,
   input  logic [RW-1:0]    i_addr,
   input  logic [REGNO-1:0] i_reg_ie,
   input  logic             i_mem_access,
   input  logic             i_mem_we,
   input  logic             i_mem_width,
   output logic [REGNO-1:0] o_reg_ie,
   output logic [RW-1:0]    o_reg_data,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [RW-2:0]    o_mem_addr,
   output logic [RW-1:0]    o_mem_data,
   output logic [1:0]       o_mem_sel,
   input  logic             i_mem_ack,
   input  logic [RW-1:0]    i_mem_data
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state;
   logic [RW-1:0]    cap_addr;
   logic [RW-1:0]    cap_data;
   logic [REGNO-1:0] cap_reg_ie;
   logic             cap_we;
   logic             cap_width;

   logic             accept_mem;
   logic [7:0]       load_lane;
   logic [RW-1:0]    load_data;

   assign accept_mem = (state == IDLE) && i_submit && i_mem_access;

   // Sequencer: capture on memory-op acceptance, release on ack.
   // The captured fields never change while BUSY.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         o_mem_req  <= 1'b0;
         cap_addr   <= '0;
         cap_data   <= '0;
         cap_reg_ie <= '0;
         cap_we     <= 1'b0;
         cap_width  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_mem) begin
                  cap_addr   <= i_addr;
                  cap_data   <= i_data;
                  cap_reg_ie <= i_reg_ie;
                  cap_we     <= i_mem_we;
                  cap_width  <= i_mem_width;
                  o_mem_req  <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (i_mem_ack) begin
                  o_mem_req <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               o_mem_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Bus fields come only from captured state, so they stay stable through the ack cycle.
   always_comb begin
      o_mem_we   = cap_we;
      o_mem_addr = cap_addr[RW-1:1];
      if (cap_width) begin
         o_mem_sel  = cap_addr[0] ? 2'b10 : 2'b01;
         o_mem_data = {(RW/8){cap_data[7:0]}};
      end else begin
         o_mem_sel  = 2'b11;
         o_mem_data = cap_data;
      end
   end

   // Format load data: zero-extend the selected byte lane for byte loads.
   always_comb begin
      load_lane = cap_addr[0] ? i_mem_data[15:8] : i_mem_data[7:0];
      if (cap_width) begin
         load_data = {{(RW-8){1'b0}}, load_lane};
      end else begin
         load_data = i_mem_data;
      end
   end

   // Handshake and writeback port. A store ack never writes a register.
   // Reset suppresses any writeback.
   always_comb begin
      o_ready    = 1'b1;
      o_reg_ie   = '0;
      o_reg_data = i_data;
      case (state)
         IDLE: begin
            o_ready = !(i_submit && i_mem_access);
            if (i_rst_n && i_submit && !i_mem_access) begin
               o_reg_ie = i_reg_ie;
            end
         end
         BUSY: begin
            o_ready    = i_mem_ack;
            o_reg_data = load_data;
            if (i_rst_n && i_mem_ack && !cap_we) begin
               o_reg_ie = cap_reg_ie;
            end
         end
         default: begin
            o_ready = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb.
// Stimulus pushes the expected bus requests and writebacks into queues.
// A monitor running on the falling edge pops and compares them.

module tb_mem_wb;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_submit;
   logic        o_ready;
   logic [15:0] i_data;
   logic [15:0] i_addr;
   logic [7:0]  i_reg_ie;
   logic        i_mem_access;
   logic        i_mem_we;
   logic        i_mem_width;
   logic [7:0]  o_reg_ie;
   logic [15:0] o_reg_data;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [14:0] o_mem_addr;
   logic [15:0] o_mem_data;
   logic [1:0]  o_mem_sel;
   logic        i_mem_ack;
   logic [15:0] i_mem_data;

   mem_wb #(.RW(16), .REGNO(8)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_submit    (i_submit),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .i_addr      (i_addr),
      .i_reg_ie    (i_reg_ie),
      .i_mem_access(i_mem_access),
      .i_mem_we    (i_mem_we),
      .i_mem_width (i_mem_width),
      .o_reg_ie    (o_reg_ie),
      .o_reg_data  (o_reg_data),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_data  (o_mem_data),
      .o_mem_sel   (o_mem_sel),
      .i_mem_ack   (i_mem_ack),
      .i_mem_data  (i_mem_data)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [14:0] addr;
      logic        we;
      logic [1:0]  sel;
      logic [15:0] wdata;
   } req_t;

   typedef struct packed {
      logic [7:0]  reg_ie;
      logic [15:0] data;
   } wb_t;

   req_t exp_req[$];
   wb_t  exp_wb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules for one memory access, written as plain arithmetic
   function automatic logic [1:0] model_sel(input bit width, input logic [15:0] addr);
      if (!width) return 2'b11;
      return 2'b01 << addr[0];
   endfunction

   function automatic logic [15:0] model_load(input bit width, input logic [15:0] addr,
                                              input logic [15:0] rdata);
      if (!width) return rdata;
      return (rdata >> (8 * int'(addr[0]))) & 16'h00FF;
   endfunction

   // Monitor: compare bus requests every cycle they are open, and every writeback.
   initial begin
      forever begin
         @(negedge i_clk);
         if (o_reg_ie !== 8'h00) begin
            if (exp_wb.size() == 0) begin
               check("unexpected_wb", {8'h00, o_reg_ie, o_reg_data}, 32'h0);
            end else begin
               wb_t e;
               e = exp_wb.pop_front();
               check("wb_reg_ie", {24'h0, o_reg_ie}, {24'h0, e.reg_ie});
               check("wb_data", {16'h0, o_reg_data}, {16'h0, e.data});
            end
         end
         if (o_mem_req === 1'b1) begin
            if (exp_req.size() == 0) begin
               check("unexpected_req", {31'h0, o_mem_req}, 32'h0);
            end else begin
               req_t r;
               r = exp_req[0];
               check("req_addr", {17'h0, o_mem_addr}, {17'h0, r.addr});
               check("req_we", {31'h0, o_mem_we}, {31'h0, r.we});
               check("req_sel", {30'h0, o_mem_sel}, {30'h0, r.sel});
               if (r.we) check("req_wdata", {16'h0, o_mem_data}, {16'h0, r.wdata});
               if (i_mem_ack) void'(exp_req.pop_front());
            end
         end
      end
   end

   task automatic do_op(input bit mem, input bit we, input bit width,
                        input logic [15:0] addr, input logic [15:0] data,
                        input logic [7:0] reg_ie, input logic [15:0] rdata,
                        input int delay);
      req_t r;
      wb_t  w;
      i_submit     = 1'b1;
      i_mem_access = mem;
      i_mem_we     = we;
      i_mem_width  = width;
      i_addr       = addr;
      i_data       = data;
      i_reg_ie     = reg_ie;
      if (!mem) begin
         w.reg_ie = reg_ie;
         w.data   = data;
         exp_wb.push_back(w);
      end else begin
         r.addr  = addr[15:1];
         r.we    = we;
         r.sel   = model_sel(width, addr);
         r.wdata = width ? {data[7:0], data[7:0]} : data;
         exp_req.push_back(r);
         if (!we) begin
            w.reg_ie = reg_ie;
            w.data   = model_load(width, addr, rdata);
            exp_wb.push_back(w);
         end
      end
      @(negedge i_clk);
      check("ready_submit", {31'h0, o_ready}, {31'h0, !mem});
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      i_addr   = 16'($urandom);
      i_data   = 16'($urandom);
      i_reg_ie = 8'($urandom);
      i_mem_we = 1'($urandom);
      i_mem_width = 1'($urandom);
      if (mem) begin
         repeat (delay) begin
            @(negedge i_clk);
            check("ready_wait", {31'h0, o_ready}, 32'h0);
            check("req_wait", {31'h0, o_mem_req}, 32'h1);
            @(posedge i_clk); #1;
         end
         i_mem_ack  = 1'b1;
         i_mem_data = rdata;
         @(negedge i_clk);
         check("ready_ack", {31'h0, o_ready}, 32'h1);
         @(posedge i_clk); #1;
         i_mem_ack  = 1'b0;
         i_mem_data = 16'($urandom);
         check("req_drop", {31'h0, o_mem_req}, 32'h0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n      = 1'b0;
      i_submit     = 1'b0;
      i_data       = '0;
      i_addr       = '0;
      i_reg_ie     = '0;
      i_mem_access = 1'b0;
      i_mem_we     = 1'b0;
      i_mem_width  = 1'b0;
      i_mem_ack    = 1'b0;
      i_mem_data   = '0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("rst_req", {31'h0, o_mem_req}, 32'h0);
      check("rst_reg_ie", {24'h0, o_reg_ie}, 32'h0);
      check("rst_ready", {31'h0, o_ready}, 32'h1);
      @(posedge i_clk); #1;

      // ALU writeback
      do_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 8'h04, 16'h0000, 0);
      // word load, three wait cycles
      do_op(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000, 8'h02, 16'hBEEF, 3);
      // byte loads, both lanes
      do_op(1'b1, 1'b0, 1'b1, 16'h0011, 16'h0000, 8'h08, 16'hA55A, 1);
      do_op(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000, 8'h10, 16'hA55A, 2);
      // byte store: no writeback despite non-zero reg_ie
      do_op(1'b1, 1'b1, 1'b1, 16'h0003, 16'h12C7, 8'h01, 16'hFFFF, 1);
      // same-cycle-ack load immediately followed by an ALU op
      do_op(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 8'h20, 16'h5A5A, 0);
      do_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h4321, 8'h40, 16'h0000, 0);

      // reset while BUSY, then a stray ack
      i_submit = 1'b1; i_mem_access = 1'b1; i_mem_we = 1'b0; i_mem_width = 1'b0;
      i_addr = 16'h0080; i_data = 16'h0000; i_reg_ie = 8'h80;
      begin
         req_t r;
         r.addr = 15'h0040; r.we = 1'b0; r.sel = 2'b11; r.wdata = 16'h0000;
         exp_req.push_back(r);
      end
      @(posedge i_clk); #1;
      i_submit = 1'b0;
      @(negedge i_clk);
      check("rst_busy_req", {31'h0, o_mem_req}, 32'h1);
      @(posedge i_clk); #1;
      i_rst_n = 1'b0; i_mem_ack = 1'b1; i_mem_data = 16'h7777;
      @(negedge i_clk);
      check("rst_ack_no_wb", {24'h0, o_reg_ie}, 32'h0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      exp_req.delete();
      check("rst_req_drop", {31'h0, o_mem_req}, 32'h0);
      check("rst_ready_idle", {31'h0, o_ready}, 32'h1);
      @(posedge i_clk); #1;
      i_mem_ack = 1'b0;
      check("rst_req_still_low", {31'h0, o_mem_req}, 32'h0);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         bit          mem;
         logic [15:0] a, d, rd;
         mem = ($urandom_range(0, 9) < 6);
         a   = 16'($urandom);
         d   = 16'($urandom);
         rd  = 16'($urandom);
         do_op(mem, 1'($urandom), 1'($urandom), a, d, 8'h01 << $urandom_range(0, 7),
               rd, int'($urandom_range(0, 3)));
      end

      @(negedge i_clk);
      check("wb_queue_empty", exp_wb.size(), 32'h0);
      check("req_queue_empty", exp_req.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
